pipe_hazard_unit: RTL

Parametrised hazard, forwarding and stall controller for the 5-stage RV32I pipeline. It replaces the fixed "stall on any in-flight write" scheme with three things: per-source forwarding, load-use detection, and branch flush priority. It also adds a variable-latency data-memory freeze. It sits beside the ID stage, tracks in-flight destinations in its own EX/MEM/WB slot shift register, and drives the pipeline-register enables and the operand muxes.

---
 rtl/pipe_hazard_unit_pkg.sv | 28 ++
 rtl/pipe_hazard_unit_src_check.sv | 51 +++++
 rtl/pipe_hazard_unit.sv | 124 ++++++++++++
 3 files changed

// File: rtl/pipe_hazard_unit_pkg.sv
// Shared definitions for the pipeline hazard/forwarding unit:
// forwarding-select codes and the layout of an in-flight slot.
package pipe_hazard_unit_pkg;

  // In-flight slots, youngest first.
  localparam int NUM_SLOTS = 3;
  localparam int SLOT_EX   = 0;
  localparam int SLOT_MEM  = 1;
  localparam int SLOT_WB   = 2;

  // Slot layout for a given RA_W: [RA_W+1] valid, [RA_W:1] rd, [0] is_load.
  localparam int SLOT_LOAD_BIT = 0;
  localparam int SLOT_RD_LSB   = 1;

  // Where an operand value comes from.
  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_EX  = 2'd1,
    FWD_MEM = 2'd2,
    FWD_WB  = 2'd3
  } fwd_sel_e;

  // Index of the valid bit inside a slot.
  function automatic int slot_valid_bit(input int ra_w);
    return ra_w + 1;
  endfunction

endpackage

// File: rtl/pipe_hazard_unit_src_check.sv
// Per-source hazard check: finds the youngest in-flight writer of one
// source register and decides whether to stall or which value to forward.
module hazard_src_check
  import pipe_hazard_unit_pkg::*;
#(
  parameter int RA_W        = 5,
  parameter int FWD_EN      = 1,
  parameter int ZERO_REG_EN = 1
) (
  input  logic [NUM_SLOTS-1:0][RA_W+1:0] slots,
  input  logic [RA_W-1:0]                src_addr,
  input  logic                           src_used,
  output logic                           stall,
  output fwd_sel_e                       fwd_sel
);

  localparam int VALID_BIT = slot_valid_bit(RA_W);

  logic [NUM_SLOTS-1:0] match;
  logic [NUM_SLOTS-1:0] needs_stall;

  // Per-slot address match and whether a match there can only be resolved by waiting.
  always_comb begin
    match       = '0;
    needs_stall = '0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      match[s] = slots[s][VALID_BIT] && src_used &&
                 (slots[s][RA_W:SLOT_RD_LSB] == src_addr) &&
                 !((ZERO_REG_EN != 0) && (src_addr == '0));
      needs_stall[s] = (FWD_EN == 0) ||
                       (slots[s][SLOT_LOAD_BIT] && (s != SLOT_WB));
    end
  end

  // Youngest matching slot decides: EX, then MEM, then WB.
  always_comb begin
    stall   = 1'b0;
    fwd_sel = FWD_RF;
    if (match[SLOT_EX]) begin
      if (needs_stall[SLOT_EX]) stall = 1'b1;
      else                      fwd_sel = FWD_EX;
    end else if (match[SLOT_MEM]) begin
      if (needs_stall[SLOT_MEM]) stall = 1'b1;
      else                       fwd_sel = FWD_MEM;
    end else if (match[SLOT_WB]) begin
      if (needs_stall[SLOT_WB]) stall = 1'b1;
      else                      fwd_sel = FWD_WB;
    end
  end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard, forwarding and stall controller for the 5-stage pipeline.
// Tracks in-flight destinations in EX/MEM/WB slots and drives the
// pipeline-register enables and operand muxes.
module pipe_hazard_unit
  import pipe_hazard_unit_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int RA_W        = 5,
  parameter int FWD_EN      = 1,
  parameter int ZERO_REG_EN = 1,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [RA_W-1:0]  id_rs1_addr,
  input  logic [RA_W-1:0]  id_rs2_addr,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [RA_W-1:0]  id_rd_addr,
  input  logic             id_rf_wen,
  input  logic             id_is_load,
  input  logic [XLEN-1:0]  rf_rs1_data,
  input  logic [XLEN-1:0]  rf_rs2_data,
  input  logic [XLEN-1:0]  ex_result,
  input  logic [XLEN-1:0]  wb_data,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             br_taken,
  output logic             stall_if,
  output logic             bubble_ex,
  output logic             flush_id,
  output logic             freeze,
  output logic [XLEN-1:0]  fwd_rs1_data,
  output logic [XLEN-1:0]  fwd_rs2_data,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic [NUM_SLOTS-1:0][RA_W+1:0] slots;
  logic [XLEN-1:0]                mem_alu_q;
  logic                           stall_rs1;
  logic                           stall_rs2;
  fwd_sel_e                       sel_rs1;
  fwd_sel_e                       sel_rs2;
  logic                           data_stall;

  hazard_src_check #(
    .RA_W        (RA_W),
    .FWD_EN      (FWD_EN),
    .ZERO_REG_EN (ZERO_REG_EN)
  ) u_check_rs1 (
    .slots    (slots),
    .src_addr (id_rs1_addr),
    .src_used (id_rs1_used),
    .stall    (stall_rs1),
    .fwd_sel  (sel_rs1)
  );

  hazard_src_check #(
    .RA_W        (RA_W),
    .FWD_EN      (FWD_EN),
    .ZERO_REG_EN (ZERO_REG_EN)
  ) u_check_rs2 (
    .slots    (slots),
    .src_addr (id_rs2_addr),
    .src_used (id_rs2_used),
    .stall    (stall_rs2),
    .fwd_sel  (sel_rs2)
  );

  // Pipeline control; a taken branch kills the stalled ID instruction, so it beats the data stall.
  always_comb begin
    freeze     = mem_req & ~mem_ready;
    data_stall = id_valid & (stall_rs1 | stall_rs2);
    flush_id   = br_taken & ~freeze;
    stall_if   = freeze | (data_stall & ~br_taken);
    bubble_ex  = data_stall & ~br_taken & ~freeze;
  end

  // Operand muxes driven by the per-source forwarding selects.
  always_comb begin
    fwd_rs1_data = rf_rs1_data;
    fwd_rs2_data = rf_rs2_data;
    case (sel_rs1)
      FWD_EX:  fwd_rs1_data = ex_result;
      FWD_MEM: fwd_rs1_data = mem_alu_q;
      FWD_WB:  fwd_rs1_data = wb_data;
      default: fwd_rs1_data = rf_rs1_data;
    endcase
    case (sel_rs2)
      FWD_EX:  fwd_rs2_data = ex_result;
      FWD_MEM: fwd_rs2_data = mem_alu_q;
      FWD_WB:  fwd_rs2_data = wb_data;
      default: fwd_rs2_data = rf_rs2_data;
    endcase
  end

  // Slot shift register; everything holds while data memory is busy.
  always_ff @(posedge clk) begin
    if (reset) begin
      slots     <= '0;
      mem_alu_q <= '0;
    end else if (!freeze) begin
      slots[SLOT_WB]  <= slots[SLOT_MEM];
      slots[SLOT_MEM] <= slots[SLOT_EX];
      mem_alu_q       <= ex_result;
      if (br_taken || data_stall) slots[SLOT_EX] <= '0;
      else slots[SLOT_EX] <= {id_valid & id_rf_wen, id_rd_addr, id_is_load};
    end
  end

  // Performance counters, wrapping naturally at their width.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_if) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_id) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule
